decoder_onehot_seq: RTL
=======================

// Module: decoder_onehot_seq
// PURPOSE
//  Registered binary-to-one-hot decoder; the receive-side counterpart of the
//  team's one-hot-to-binary encoder. Accepts a W-bit code via valid/ready,
//  drives exactly one of 2**W select lines for HOLD cycles, then forces a GAP
//  of all-zero cycles (break-before-make) before accepting the next code.
//  Sits between a code source (encoder, CPU reg) and one-hot enable lines.
// PARAMETERS
//  W     2  code width; y is 2**W bits wide (W >= 1)
//  HOLD  4  cycles y stays one-hot per accepted code (HOLD >= 1)
//  GAP   1  all-zero cycles after HOLD before next accept (GAP >= 0)
// PORTS
//  clk        in   1       rising-edge clock; single clock domain
//  rst_n      in   1       asynchronous active-low reset
//  e          in   1       enable; low aborts output and blocks accepts
//  in_valid   in   1       code on `code` is valid
//  in_ready   out  1       block can accept a code this cycle
//  code       in   W       binary code to decode
//  y          out  2**W    registered one-hot select lines
//  busy       out  1       high in DRIVE or GAP
//  done       out  1       1-cycle pulse on last HOLD cycle of a code
// BEHAVIOUR
//  - Reset (async on rst_n low, released sync): state=IDLE, y=0, busy=0,
//    done=0, counter=0, in_ready=0 while rst_n low.
//  - in_ready = (state==IDLE) & e; combinational. Accept = in_valid & in_ready.
//  - FSM states: IDLE, DRIVE, GAP.
//    IDLE : on accept -> DRIVE; y <= 1<<code on the same edge (latency 1 cycle
//           from accept edge); counter <= HOLD-1. code is latched; later code
//           changes have no effect.
//    DRIVE: y held; counter decrements each cycle; when counter==0:
//           done=1 that cycle; next -> GAP (y<=0, counter<=GAP-1) if GAP>0,
//           else -> IDLE (y<=0).
//    GAP  : y=0; counter decrements; at 0 -> IDLE.
//  - e low in any state: next edge -> IDLE, y<=0, counter<=0, no done pulse.
//    e low in IDLE: in_ready=0, in_valid ignored (no accept, no queueing).
//  - busy = (state!=IDLE). done asserted only in DRIVE with counter==0 and e=1.
//  - y is never two-hot; y is zero in IDLE and GAP and during reset.
//  - Back-to-back: with GAP=0, new accept possible the cycle after DRIVE ends;
//    min spacing between accepts = HOLD+GAP+1 cycles.
//  - Counter width = clog2(max(HOLD,GAP,2)); no wrap: counter never
//    decrements below 0.
//  - code out of range impossible (2**W outputs cover all codes).
//  - rst_n low mid-DRIVE/GAP: y=0 immediately (async), state IDLE.
// TESTING
//  1. Reset: rst_n=0 with y driven -> y=0000, busy=0, in_ready=0 at once.
//  2. W=2,HOLD=4,GAP=1: accept code=2 -> y=0100 for 4 cycles from next edge,
//     done on 4th, y=0000 1 cycle, then in_ready=1.
//  3. Sweep codes 0..3 back-to-back, in_valid held high -> y=0001,0010,0100,
//     1000 each 4 cycles, separated by one 0000 cycle; never two-hot.
//  4. e dropped on 2nd DRIVE cycle of code=3 -> y=0000 next edge, no done,
//     in_ready stays 0 until e=1, then accept code=1 -> y=0010.
//  5. Change `code` during DRIVE (2->1) -> y stays 0100 until HOLD expires.
//  6. rst_n pulsed low mid-GAP and mid-DRIVE -> y=0 immediately, resumes in
//     IDLE; GAP=0 config: accepts spaced exactly HOLD+1 cycles.

Source files
------------

// File: rtl/decoder_onehot_seq_if.sv
// Handshake and select-line bundle between a code source and the one-hot decoder.
interface decoder_onehot_seq_if #(
    parameter int W = 2
);
    logic            e;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    code;
    logic [2**W-1:0] y;
    logic            busy;
    logic            done;

    modport master (
        output e, in_valid, code,
        input  in_ready, y, busy, done
    );

    modport slave (
        input  e, in_valid, code,
        output in_ready, y, busy, done
    );
endinterface

// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with hold time and break-before-make gap.
module decoder_onehot_seq #(
    parameter int W    = 2,
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input logic            clk,
    input logic            rst_n,
    decoder_onehot_seq_if.slave bus
);
    localparam int N    = 2**W;
    localparam int MAXV = (HOLD > GAP) ? ((HOLD > 2) ? HOLD : 2) : ((GAP > 2) ? GAP : 2);
    localparam int CW   = $clog2(MAXV);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [N-1:0]  y_q, y_next;
    logic          done_c;
    logic          ready_c;
    logic          accept;

    // Ready is forced low while reset is held, even though the state is already IDLE.
    assign ready_c = (state == S_IDLE) && bus.e && rst_n;
    assign accept  = bus.in_valid && ready_c;

    assign bus.in_ready = ready_c;
    assign bus.y        = y_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_c;

    // State, hold/gap counter and select lines; async clear so y drops immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            y_q   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            y_q   <= y_next;
        end
    end

    // Next-state, counter and select-line decode; a low enable aborts from any state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        y_next     = y_q;
        done_c     = 1'b0;

        if (!bus.e) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            y_next     = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    y_next = '0;
                    if (accept) begin
                        state_next      = S_DRIVE;
                        y_next[bus.code] = 1'b1;
                        cnt_next        = HOLD_LOAD;
                    end
                end
                S_DRIVE: begin
                    if (cnt == '0) begin
                        done_c = 1'b1;
                        y_next = '0;
                        if (GAP > 0) begin
                            state_next = S_GAP;
                            cnt_next   = GAP_LOAD;
                        end else begin
                            state_next = S_IDLE;
                            cnt_next   = '0;
                        end
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    y_next = '0;
                    if (cnt == '0) begin
                        state_next = S_IDLE;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    y_next     = '0;
                end
            endcase
        end
    end
endmodule
